jtcontra_pal_arb: RTL and testbench

Arbiter and sequencer for a single-port 256×8 palette RAM shared between the video colour lookup and the main CPU. It replaces a dual-port palette by time-slicing one port: per pixel, two clock slots fetch the low and high colour bytes, and the remaining slots serve CPU reads and writes through a wait/ok handshake. It sits between the tile/sprite priority mux, which supplies the 7-bit colour index, and the blanking delay stage, which consumes the 15-bit BGR word.

---
 rtl/jtcontra_pal_arb_pkg.sv | 25 ++
 rtl/jtcontra_pal_arb.sv | 135 +++++++++++++
 tb/tb_jtcontra_pal_arb.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jtcontra_pal_arb_pkg.sv
// Shared slot numbering, CPU sequencer states and colour packing for the
// time-sliced palette RAM arbiter.
package jtcontra_pal_arb_pkg;

  // Slot numbers within one pixel (four clk cycles per pixel)
  localparam logic [1:0] SLOT_LO   = 2'd0;  // video fetch, low colour byte
  localparam logic [1:0] SLOT_HI   = 2'd1;  // video fetch, high colour byte
  localparam logic [1:0] SLOT_CPU0 = 2'd2;  // CPU slot; also video capture
  localparam logic [1:0] SLOT_CPU1 = 2'd3;  // CPU slot

  // CPU access sequencer
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } cpu_st_e;

  // Join the two palette bytes into {blue,green,red}; bit 7 of the high byte
  // is not part of the colour and is never passed in.
  function automatic logic [14:0] pack_bgr(input logic [6:0] hi7,
                                           input logic [7:0] lo8);
    return {hi7, lo8};
  endfunction

endpackage

// File: rtl/jtcontra_pal_arb.sv
// Single-port palette RAM arbiter: two slots per pixel fetch the colour
// bytes for video, the remaining slots serve CPU reads and writes with a
// cs/ok handshake. During blanking the video slots can be handed to the CPU.
module jtcontra_pal_arb
  import jtcontra_pal_arb_pkg::*;
#(
  parameter int BLANK_FREE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        LHBL,
  input  logic        LVBL,
  input  logic        cpu_cs,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ok,
  input  logic [6:0]  vid_idx,
  output logic [14:0] vid_rgb,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic [7:0]  ram_q
);

  logic [1:0]  ph_q, ph_d;
  logic [1:0]  slot;
  logic        blank;
  logic        vid_own;
  logic        cpu_slot;
  logic        grant;

  cpu_st_e     st_q, st_d;
  logic        rnw_q, rnw_d;
  logic        ok_q, ok_d;
  logic [7:0]  dout_q, dout_d;

  logic [7:0]  lo_q, lo_d;
  logic [14:0] rgb_q, rgb_d;

  logic [7:0]  addr_q, addr_d;
  logic        we_c;

  // Slot decode and port ownership for the current cycle
  always_comb begin
    slot     = pxl_cen ? SLOT_LO : ph_q;
    blank    = ~LHBL | ~LVBL;
    vid_own  = ~rst & ~blank & ((slot == SLOT_LO) | (slot == SLOT_HI));
    cpu_slot = (slot == SLOT_CPU0) | (slot == SLOT_CPU1) |
               (blank & (BLANK_FREE != 0));
    grant    = ~rst & (st_q == ST_IDLE) & cpu_cs & cpu_slot;
    ph_d     = pxl_cen ? 2'd1 : ph_q + 2'd1;
  end

  // RAM port drive: video first, then a fresh CPU grant, otherwise hold address
  always_comb begin
    addr_d = addr_q;
    we_c   = 1'b0;
    if (vid_own) begin
      addr_d = {vid_idx, slot[0]};
    end else if (grant) begin
      addr_d = cpu_addr;
      we_c   = ~cpu_rnw;
    end
  end

  // CPU sequencer: grant cycle issues the access, ACC collects it, DONE holds ok
  always_comb begin
    st_d   = st_q;
    rnw_d  = rnw_q;
    ok_d   = ok_q;
    dout_d = dout_q;
    case (st_q)
      ST_IDLE: begin
        if (grant) begin
          rnw_d = cpu_rnw;
          st_d  = ST_ACC;
        end
      end
      ST_ACC: begin
        if (rnw_q) dout_d = ram_q;
        ok_d = 1'b1;
        st_d = ST_DONE;
      end
      ST_DONE: begin
        if (!cpu_cs) begin
          ok_d = 1'b0;
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Video capture: low byte arrives in slot 1, high byte in slot 2
  always_comb begin
    lo_d  = lo_q;
    rgb_d = rgb_q;
    if (slot == SLOT_HI) lo_d = ram_q;
    if (slot == SLOT_CPU0) rgb_d = blank ? 15'd0 : pack_bgr(ram_q[6:0], lo_q);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q   <= 2'd0;
      st_q   <= ST_IDLE;
      rnw_q  <= 1'b0;
      ok_q   <= 1'b0;
      dout_q <= 8'd0;
      lo_q   <= 8'd0;
      rgb_q  <= 15'd0;
      addr_q <= 8'd0;
    end else begin
      ph_q   <= ph_d;
      st_q   <= st_d;
      rnw_q  <= rnw_d;
      ok_q   <= ok_d;
      dout_q <= dout_d;
      lo_q   <= lo_d;
      rgb_q  <= rgb_d;
      addr_q <= addr_d;
    end
  end

  assign ram_addr = addr_d;
  assign ram_we   = we_c;
  assign ram_din  = cpu_din;
  assign cpu_ok   = ok_q;
  assign cpu_dout = dout_q;
  assign vid_rgb  = rgb_q;

endmodule

// File: tb/tb_jtcontra_pal_arb.sv
// Bench for the palette arbiter: a behavioural palette RAM, a shadow copy of
// its intended contents, directed scenarios and a randomized traffic phase.
module tb_jtcontra_pal_arb;

  logic        clk = 1'b0;
  logic        rst, pxl_cen, LHBL, LVBL, cpu_cs, cpu_rnw;
  logic [7:0]  cpu_addr, cpu_din, cpu_dout;
  logic        cpu_ok;
  logic [6:0]  vid_idx;
  logic [14:0] vid_rgb;
  logic [7:0]  ram_addr, ram_din, ram_q;
  logic        ram_we;

  logic [7:0]  mem    [256];
  logic [7:0]  shadow [256];
  logic        bd_we;
  logic [7:0]  bd_addr, bd_data;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;

  bit          auto_vid  = 1'b0;
  bit          pix_valid = 1'b0;
  bit          pix_blank = 1'b0;
  logic [6:0]  pix_idx   = 7'd0;

  bit          obs_ok;
  logic [7:0]  obs_dout;
  int          obs_cyc, obs_slot;
  int          we_cnt, we_slot;

  logic [7:0]  q, a, d, expd;
  int          lat, oks, okcnt;
  bit          rnw;

  always #5 clk = ~clk;

  jtcontra_pal_arb #(.BLANK_FREE(1)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .cpu_cs(cpu_cs), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ok(cpu_ok), .vid_idx(vid_idx), .vid_rgb(vid_rgb),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_q(ram_q)
  );

  // Palette RAM with one-clock read latency, plus a preload port
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_q <= mem[ram_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Colour the video path should show for a pixel, from the intended RAM image
  function automatic logic [14:0] exp_rgb(input logic [6:0] idx, input bit blk);
    logic [7:0] lo, hi;
    lo = shadow[{idx, 1'b0}];
    hi = shadow[{idx, 1'b1}];
    if (blk) return 15'd0;
    return {hi[6:0], lo};
  endfunction

  // One clk cycle: drive pixel timing, observe mid-cycle, advance
  task automatic cyc_tick();
    int slot;
    bit blank;
    slot = cyc % 4;
    if (auto_vid && slot == 0) begin
      vid_idx = 7'($urandom_range(0, 63));
      LVBL    = ($urandom_range(0, 5) != 0);
      LHBL    = ($urandom_range(0, 5) != 0);
    end
    pxl_cen = (slot == 0);
    #1;
    blank = !LHBL || !LVBL;
    if (rst) begin
      pix_valid = 1'b0;
    end else begin
      if (slot == 0) begin
        pix_valid = 1'b1;
        pix_idx   = vid_idx;
      end
      if (slot == 2) pix_blank = blank;
      if (!blank && slot < 2) chk("vid_addr", ram_addr, {vid_idx, slot[0]});
      if (ram_we) begin
        we_cnt++;
        we_slot = slot;
        chk("we_in_video_slot", (!blank && slot < 2), 0);
        chk("we_addr", ram_addr, cpu_addr);
        chk("we_data", ram_din, cpu_din);
      end
      if (slot == 3 && pix_valid) chk("vid_rgb", vid_rgb, exp_rgb(pix_idx, pix_blank));
    end
    obs_ok   = cpu_ok;
    obs_dout = cpu_dout;
    obs_cyc  = cyc;
    obs_slot = slot;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Full CPU handshake; lat counts cycles from cs rising to cpu_ok visible
  task automatic cpu_access(input bit r, input logic [7:0] ad, input logic [7:0] dd,
                            output logic [7:0] qq, output int lt, output int okslot);
    int c0;
    c0       = cyc;
    cpu_cs   = 1'b1;
    cpu_rnw  = r;
    cpu_addr = ad;
    cpu_din  = dd;
    lt       = -1;
    qq       = 8'd0;
    okslot   = -1;
    for (int n = 0; n < 16 && lt < 0; n++) begin
      cyc_tick();
      if (obs_ok) begin
        lt     = obs_cyc - c0;
        qq     = obs_dout;
        okslot = obs_slot;
      end
    end
    if (lt < 0) chk("ok_timeout", obs_ok, 1);
    cpu_cs = 1'b0;
    for (int n = 0; n < 6 && obs_ok; n++) cyc_tick();
    chk("ok_release", obs_ok, 0);
    if (!r) shadow[ad] = dd;
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
    cpu_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = 8'd0; cpu_din = 8'd0;
    vid_idx = 7'd0; bd_we = 1'b0; bd_addr = 8'd0; bd_data = 8'd0;
    we_cnt = 0; we_slot = -1;

    // Preload the palette while the arbiter is held in reset
    for (int i = 0; i < 256; i++) begin
      bd_we   = 1'b1;
      bd_addr = 8'(i);
      bd_data = (i == 8'h0A) ? 8'h34 : (i == 8'h0B) ? 8'hF2 : 8'($urandom_range(0, 255));
      shadow[i] = bd_data;
      @(posedge clk);
      @(negedge clk);
    end
    bd_we = 1'b0;

    chk("rst_cpu_ok",   cpu_ok,   0);
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_vid_rgb",  vid_rgb,  0);
    chk("rst_ram_we",   ram_we,   0);
    chk("rst_ram_addr", ram_addr, 0);

    // Known colour fetch
    rst = 1'b0; cyc = 0; vid_idx = 7'h05;
    repeat (4) cyc_tick();
    chk("vid_7234", vid_rgb, 15'h7234);

    // Write raised in slot 0 of active video, then read it back
    we_cnt = 0; we_slot = -1;
    cpu_access(1'b0, 8'h10, 8'hAB, q, lat, oks);
    chk("wr_we_count", we_cnt, 1);
    chk("wr_we_slot",  we_slot, 2);
    chk("wr_latency",  lat, 4);
    chk("wr_ok_slot",  oks, 0);
    cpu_access(1'b1, 8'h10, 8'h00, q, lat, oks);
    chk("rd_back", q, 8'hAB);

    // Read raised in slot 3 returns across the next video slot 0
    while (cyc % 4 != 3) cyc_tick();
    a = 8'($urandom_range(64, 127));
    expd = shadow[a];
    cpu_access(1'b1, a, 8'h00, q, lat, oks);
    chk("rd_slot3_data",    q, expd);
    chk("rd_slot3_latency", lat, 2);
    chk("rd_slot3_ok_slot", oks, 1);

    // Vertical blanking: slot 0 goes to the CPU and the colour is blanked
    while (cyc % 4 != 0) cyc_tick();
    LVBL = 1'b0; we_cnt = 0; we_slot = -1;
    cpu_access(1'b0, 8'h90, 8'h5C, q, lat, oks);
    chk("blank_we_slot", we_slot, 0);
    chk("blank_latency", lat, 2);
    chk("blank_rgb",     vid_rgb, 0);
    while (cyc % 4 != 0) cyc_tick();
    LVBL = 1'b1;

    // Reset during the ACC cycle of a read
    while (cyc % 4 != 2) cyc_tick();
    cpu_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 8'h20;
    cyc_tick();
    rst = 1'b1;
    cyc_tick();
    rst = 1'b0; cpu_cs = 1'b0; cyc = 0;
    cyc_tick();
    chk("rst_acc_ok",   obs_ok, 0);
    chk("rst_acc_dout", obs_dout, 0);
    expd = shadow[8'h21];
    cpu_access(1'b1, 8'h21, 8'h00, q, lat, oks);
    chk("post_rst_data",    q, expd);
    chk("post_rst_latency", lat, 3);

    // One-cycle request pulse in a video slot is abandoned
    while (cyc % 4 != 0) cyc_tick();
    we_cnt = 0; okcnt = 0;
    cpu_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 8'hA5; cpu_din = 8'h11;
    cyc_tick();
    cpu_cs = 1'b0;
    repeat (8) begin
      cyc_tick();
      okcnt += int'(obs_ok);
    end
    chk("pulse_no_write", we_cnt, 0);
    chk("pulse_no_ok",    okcnt, 0);

    // Random traffic with random per-pixel blanking
    auto_vid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 5)) cyc_tick();
      rnw = 1'($urandom_range(0, 1));
      a   = rnw ? 8'($urandom_range(0, 255)) : 8'($urandom_range(128, 255));
      d   = 8'($urandom_range(0, 255));
      expd = shadow[a];
      cpu_access(rnw, a, d, q, lat, oks);
      if (rnw) chk("rnd_read", q, expd);
      chk("rnd_latency_bound", (lat >= 2 && lat <= 4), 1);
    end
    auto_vid = 1'b0;
    repeat (8) cyc_tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
